// File: rtl/fetch_sequencer.sv
// fetch_sequencer: owns the PC, issues one instruction-memory fetch at a time
// over a level req / pulse ack handshake, and hands each fetched instruction to
// decode over a valid/stall handshake. Branch redirects overwrite the PC and
// cause any stale in-flight fetch to be discarded.
//
// Ports:
//   clk, reset         rising-edge clock, synchronous active-high reset
//   imem_req/addr      fetch request (level) and its address, held until ack
//   imem_ack/rdata     one-cycle completion pulse with the fetched word
//   instr_valid/out/pc instruction presented to decode
//   stall              decode back-pressure; transfer when valid && !stall
//   branch_taken/target redirect pulse and destination (low 2 bits ignored)
//   pc_out             current PC register
//   delivered_cnt      number of instructions accepted by decode
module fetch_sequencer #(
    parameter int                ADDR_W      = 64,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter int                INSTR_BYTES = 4,
    parameter int                CNT_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    output logic [ADDR_W-1:0] pc_out,
    output logic [CNT_W-1:0]  delivered_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, DELIVER} state_t;

    state_t            state;
    logic [ADDR_W-1:0] pc;
    logic              drop;   // outstanding fetch belongs to a redirected-away path
    logic [ADDR_W-1:0] target_aligned;
    logic [ADDR_W-1:0] pc_seq;

    assign target_aligned = branch_target & ~ADDR_W'(3);
    assign pc_seq         = pc + ADDR_W'(INSTR_BYTES);
    assign pc_out         = pc;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            pc            <= RESET_PC;
            drop          <= 1'b0;
            imem_req      <= 1'b0;
            imem_addr     <= '0;
            instr_valid   <= 1'b0;
            instr_out     <= '0;
            instr_pc      <= '0;
            delivered_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // First fetch goes out the cycle after reset falls; a
                    // redirect in this cycle is folded into that first address.
                    state     <= FETCH;
                    imem_req  <= 1'b1;
                    if (branch_taken) begin
                        pc        <= target_aligned;
                        imem_addr <= target_aligned;
                    end else begin
                        imem_addr <= pc;
                    end
                end

                FETCH: begin
                    if (!imem_req) begin
                        // Issue cycle. A redirect here just moves the PC and
                        // delays the request so imem_addr is never retargeted
                        // under a live request.
                        if (branch_taken) begin
                            pc <= target_aligned;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= pc;
                        end
                    end else if (imem_ack) begin
                        imem_req <= 1'b0;
                        if (branch_taken || drop) begin
                            // Stale data: discard and refetch from the new PC.
                            drop <= 1'b0;
                            if (branch_taken)
                                pc <= target_aligned;
                        end else begin
                            instr_out   <= imem_rdata;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc_seq;
                            state       <= DELIVER;
                        end
                    end else if (branch_taken) begin
                        // Request stays outstanding at the old address; mark
                        // its eventual data for discard.
                        pc   <= target_aligned;
                        drop <= 1'b1;
                    end
                end

                DELIVER: begin
                    if (branch_taken) begin
                        instr_valid <= 1'b0;
                        pc          <= target_aligned;
                        state       <= FETCH;
                    end else if (!stall) begin
                        instr_valid   <= 1'b0;
                        delivered_cnt <= delivered_cnt + 1'b1;
                        state         <= FETCH;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_sequencer.sv
module tb_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req, imem_ack = 1'b0;
    logic [63:0] imem_addr;
    logic [31:0] imem_rdata = '0;
    logic        instr_valid, stall = 1'b0, branch_taken = 1'b0;
    logic [31:0] instr_out;
    logic [63:0] instr_pc, branch_target = '0, pc_out;
    logic [31:0] delivered_cnt;

    // second instance for PC wrap-around
    logic        w_reset = 1'b1, w_req, w_ack = 1'b0, w_valid;
    logic [63:0] w_addr, w_ipc, w_pc;
    logic [31:0] w_rdata = 32'h0BAD_F00D, w_iout, w_cnt;
    logic        w_ack_en = 1'b0;

    always #5 clk = ~clk;

    fetch_sequencer dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr_valid(instr_valid), .instr_out(instr_out), .instr_pc(instr_pc),
        .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
        .pc_out(pc_out), .delivered_cnt(delivered_cnt)
    );

    fetch_sequencer #(.RESET_PC(64'hFFFF_FFFF_FFFF_FFFC)) dut_w (
        .clk(clk), .reset(w_reset),
        .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata),
        .instr_valid(w_valid), .instr_out(w_iout), .instr_pc(w_ipc),
        .stall(1'b0), .branch_taken(1'b0), .branch_target(64'h0),
        .pc_out(w_pc), .delivered_cnt(w_cnt)
    );

    typedef struct {
        logic [63:0] pc;
        logic [31:0] data;
        logic [31:0] cnt;
    } del_t;

    del_t        exp_del[$];
    logic [63:0] exp_req[$];
    logic [63:0] exp_wreq[$];
    int          acc_cyc[$];
    int          total = 0, bad = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    bit          ack_en = 1'b0;

    function automatic logic [31:0] mdata(logic [63:0] a);
        return a[31:0] ^ 32'hC0DE_0000;
    endfunction

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic fail(string name, logic [63:0] act);
        total++;
        bad++;
        $display("FAIL %s: got %0h want none", name, act);
    endtask

    task automatic push_del(logic [63:0] pc, logic [31:0] cnt);
        del_t d;
        d.pc = pc; d.data = mdata(pc); d.cnt = cnt;
        exp_del.push_back(d);
    endtask

    task automatic tick();
        @(posedge clk); #2;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // memory model: ack after ack_delay extra cycles of a held request
    initial begin
        int wcnt = 0;
        forever begin
            @(posedge clk); #1;
            if (imem_ack) begin
                imem_ack = 1'b0;
                wcnt = 0;
            end else if (imem_req && ack_en) begin
                if (wcnt == ack_delay) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mdata(imem_addr);
                end else begin
                    wcnt++;
                end
            end else begin
                wcnt = 0;
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk); #1;
            w_ack = w_req && !w_ack && w_ack_en;
        end
    end

    // monitor / scoreboard for the main instance
    logic        req_q = 1'b0;
    logic [63:0] addr_q = '0;
    always @(negedge clk) begin
        if (!reset) begin
            if (imem_req && !req_q) begin
                if (exp_req.size() == 0) fail("req_unexpected", imem_addr);
                else chk("req_addr", imem_addr, exp_req.pop_front());
            end
            if (imem_req && req_q) chk("addr_stable", imem_addr, addr_q);
            if (instr_valid && !branch_taken) begin
                if (exp_del.size() == 0) fail("instr_unexpected", instr_pc);
                else begin
                    chk("instr_pc", instr_pc, exp_del[0].pc);
                    chk("instr_out", {32'h0, instr_out}, {32'h0, exp_del[0].data});
                    if (!stall) begin
                        chk("delivered_cnt", {32'h0, delivered_cnt}, {32'h0, exp_del[0].cnt});
                        acc_cyc.push_back(cyc);
                        exp_del.delete(0);
                    end
                end
            end
        end
        req_q  <= imem_req;
        addr_q <= imem_addr;
    end

    logic w_req_q = 1'b0;
    always @(negedge clk) begin
        if (!w_reset && w_req && !w_req_q) begin
            if (exp_wreq.size() == 0) fail("wrap_req_unexpected", w_addr);
            else chk("wrap_req_addr", w_addr, exp_wreq.pop_front());
        end
        w_req_q <= w_req;
    end

    task automatic do_reset();
        reset = 1'b1;
        tick(); tick();
        chk("rst_req", {63'h0, imem_req}, 64'h0);
        chk("rst_valid", {63'h0, instr_valid}, 64'h0);
        chk("rst_pc", pc_out, 64'h0);
        chk("rst_cnt", {32'h0, delivered_cnt}, 64'h0);
        chk("rst_addr", imem_addr, 64'h0);
        chk("rst_instr", {32'h0, instr_out}, 64'h0);
        reset = 1'b0;
    endtask

    task automatic wait_cnt(int n, int budget);
        int k = 0;
        while (delivered_cnt != 32'(n) && k < budget) begin tick(); k++; end
        chk("cnt_reach", {32'h0, delivered_cnt}, 64'(n));
    endtask

    task automatic wait_valid(int budget, output int k);
        k = 0;
        while (!instr_valid && k < budget) begin tick(); k++; end
        chk("valid_seen", {63'h0, instr_valid}, 64'h1);
    endtask

    task automatic drain_check(string name);
        chk({name, "_req_q"}, 64'(exp_req.size()), 64'h0);
        chk({name, "_del_q"}, 64'(exp_del.size()), 64'h0);
    endtask

    initial begin
        int k;
        tick();

        // 1: zero-wait streaming
        ack_en = 1'b1; ack_delay = 0; stall = 1'b0;
        exp_req = '{64'h0, 64'h4, 64'h8, 64'hC};
        push_del(64'h0, 0); push_del(64'h4, 1); push_del(64'h8, 2);
        acc_cyc.delete();
        do_reset();
        wait_cnt(3, 30);
        ack_en = 1'b0;
        tick(); tick(); tick();
        drain_check("s1");
        chk("s1_acc_n", 64'(acc_cyc.size()), 64'h3);
        if (acc_cyc.size() == 3) begin
            chk("s1_gap0", 64'(acc_cyc[1] - acc_cyc[0]), 64'h3);
            chk("s1_gap1", 64'(acc_cyc[2] - acc_cyc[1]), 64'h3);
        end

        // 2: ack delayed 3 cycles, stall 2 cycles in DELIVER
        ack_delay = 3; ack_en = 1'b1; stall = 1'b1;
        exp_req = '{64'h0, 64'h4};
        push_del(64'h0, 0);
        do_reset();
        wait_valid(20, k);
        chk("s2_latency", 64'(k), 64'h5);
        tick();
        chk("s2_cnt_stalled", {32'h0, delivered_cnt}, 64'h0);
        chk("s2_valid_held", {63'h0, instr_valid}, 64'h1);
        tick();
        stall = 1'b0;
        wait_cnt(1, 10);
        ack_en = 1'b0;
        tick(); tick(); tick();
        drain_check("s2");

        // 3: redirect while fetch of 0x8 is outstanding
        ack_delay = 0; ack_en = 1'b1;
        exp_req = '{64'h0, 64'h4, 64'h8, 64'h1000, 64'h1004};
        push_del(64'h0, 0); push_del(64'h4, 1); push_del(64'h1000, 2);
        do_reset();
        wait_cnt(2, 20);
        ack_delay = 2;
        tick();
        chk("s3_req8", {imem_req, imem_addr[62:0]}, {1'b1, 63'h8});
        branch_taken = 1'b1; branch_target = 64'h1002;
        tick();
        branch_taken = 1'b0;
        chk("s3_pc_redirect", pc_out, 64'h1000);
        tick(); tick();
        chk("s3_cnt_unchanged", {32'h0, delivered_cnt}, 64'h2);
        wait_cnt(3, 30);
        ack_en = 1'b0;
        tick(); tick(); tick();
        drain_check("s3");

        // 4: redirect in DELIVER with stall=0
        ack_delay = 0; ack_en = 1'b1;
        exp_req = '{64'h0, 64'h40, 64'h44};
        push_del(64'h40, 0);
        do_reset();
        wait_valid(10, k);
        branch_taken = 1'b1; branch_target = 64'h40;
        tick();
        branch_taken = 1'b0;
        chk("s4_valid_drop", {63'h0, instr_valid}, 64'h0);
        chk("s4_cnt_nochg", {32'h0, delivered_cnt}, 64'h0);
        chk("s4_pc", pc_out, 64'h40);
        wait_cnt(1, 20);
        ack_en = 1'b0;
        tick(); tick(); tick();
        drain_check("s4");

        // 5: reset while a request to 0x44 is outstanding
        exp_req.push_back(64'h0);
        do_reset();
        tick();
        chk("s5_restart_req", {63'h0, imem_req}, 64'h1);
        tick(); tick();
        drain_check("s5");

        // 6: PC wrap-around from the top of the address space
        exp_wreq = '{64'hFFFF_FFFF_FFFF_FFFC, 64'h0};
        w_ack_en = 1'b1;
        w_reset = 1'b0;
        k = 0;
        while (w_cnt != 32'd1 && k < 20) begin tick(); k++; end
        chk("w_cnt", {32'h0, w_cnt}, 64'h1);
        w_ack_en = 1'b0;
        tick(); tick(); tick();
        chk("w_pc_wrapped", w_pc, 64'h0);
        chk("w_req_q", 64'(exp_wreq.size()), 64'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
